// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable terminal value, synchronous load, wrap or
// saturate at the limits, registered boundary pulses and a sticky error flag.
module updown_counter_mod #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             sticky_err,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CntZero = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             sticky_q, sticky_d;

    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (enable) begin
            if (up_down) begin
                if (count_q == MAX_VAL) begin
                    overflow_d = 1'b1;
                    count_d    = SATURATE ? MAX_VAL : CntZero;
                end else begin
                    count_d = count_q + CntOne;
                end
            end else begin
                if (count_q == CntZero) begin
                    underflow_d = 1'b1;
                    count_d     = SATURATE ? CntZero : MAX_VAL;
                end else begin
                    count_d = count_q - CntOne;
                end
            end
        end

        // A new error event takes precedence over a coincident clear.
        sticky_d = sticky_q;
        if (clr_flags) begin
            sticky_d = 1'b0;
        end
        if (overflow_d || underflow_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            sticky_q    <= sticky_d;
        end
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign sticky_err = sticky_q;
    assign at_max     = (count_q == MAX_VAL);
    assign at_min     = (count_q == CntZero);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench: four counter configurations, directed steps push expected
// post-edge state; a negedge monitor pops and compares.
module tb_updown_counter_mod;

    localparam int NDut = 4;
    // 0: default (255, wrap)  1: max 9 wrap  2: max 9 saturate  3: max 99 wrap
    localparam logic [7:0] MaxV [NDut] = '{8'd255, 8'd9, 8'd9, 8'd99};
    localparam bit         SatV [NDut] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_a    [NDut];
    logic       en_a     [NDut];
    logic       ud_a     [NDut];
    logic       ld_a     [NDut];
    logic [7:0] lv_a     [NDut];
    logic       clr_a    [NDut];
    logic [7:0] cnt_a    [NDut];
    logic       ov_a     [NDut];
    logic       un_a     [NDut];
    logic       st_a     [NDut];
    logic       amax_a   [NDut];
    logic       amin_a   [NDut];

    always #5 clk = ~clk;

    updown_counter_mod #(
        .WIDTH    (8)
    ) u_dut0 (
        .clk(clk), .rst(rst_a[0]), .enable(en_a[0]), .up_down(ud_a[0]), .load(ld_a[0]),
        .load_val(lv_a[0]), .clr_flags(clr_a[0]), .count(cnt_a[0]), .overflow(ov_a[0]),
        .underflow(un_a[0]), .sticky_err(st_a[0]), .at_max(amax_a[0]), .at_min(amin_a[0])
    );

    for (genvar g = 1; g < NDut; g++) begin : g_dut
        updown_counter_mod #(
            .WIDTH    (8),
            .MAX_VAL  (MaxV[g]),
            .SATURATE (SatV[g])
        ) u_dut (
            .clk(clk), .rst(rst_a[g]), .enable(en_a[g]), .up_down(ud_a[g]), .load(ld_a[g]),
            .load_val(lv_a[g]), .clr_flags(clr_a[g]), .count(cnt_a[g]), .overflow(ov_a[g]),
            .underflow(un_a[g]), .sticky_err(st_a[g]), .at_max(amax_a[g]),
            .at_min(amin_a[g])
        );
    end

    typedef struct {
        int         cyc;
        int         d;
        logic [7:0] cnt;
        logic       ov;
        logic       un;
        logic       st;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            exp_t       e;
            logic [11:0] act, req;
            e   = sb.pop_front();
            req = {e.cnt, e.ov, e.un, e.st, 1'b0};
            act = {cnt_a[e.d], ov_a[e.d], un_a[e.d], st_a[e.d], 1'b0};
            checks++;
            if (act !== req || amax_a[e.d] !== (e.cnt == MaxV[e.d]) ||
                amin_a[e.d] !== (e.cnt == 8'd0)) begin
                errors++;
                $display("FAIL %s dut%0d: got cnt=%0d ov=%b un=%b st=%b amax=%b amin=%b, want cnt=%0d ov=%b un=%b st=%b amax=%b amin=%b",
                         e.name, e.d, cnt_a[e.d], ov_a[e.d], un_a[e.d], st_a[e.d],
                         amax_a[e.d], amin_a[e.d], e.cnt, e.ov, e.un, e.st,
                         (e.cnt == MaxV[e.d]), (e.cnt == 8'd0));
            end
        end
    end

    task automatic idle_all();
        for (int i = 0; i < NDut; i++) begin
            rst_a[i] = 1'b0; en_a[i] = 1'b0; ud_a[i] = 1'b0;
            ld_a[i]  = 1'b0; lv_a[i] = 8'd0; clr_a[i] = 1'b0;
        end
    endtask

    task automatic push(input int d, input logic [7:0] c, input logic ov, input logic un,
                        input logic st, input string name);
        exp_t e;
        e.cyc = cyc_cnt + 1; e.d = d; e.cnt = c; e.ov = ov; e.un = un; e.st = st;
        e.name = name;
        sb.push_back(e);
    endtask

    // One clock of stimulus to dut d; others idle.
    task automatic step(input int d, input bit r, input bit en, input bit ud, input bit ld,
                        input logic [7:0] lv, input bit clr, input logic [7:0] c,
                        input logic ov, input logic un, input logic st, input string name);
        @(negedge clk);
        idle_all();
        rst_a[d] = r; en_a[d] = en; ud_a[d] = ud; ld_a[d] = ld; lv_a[d] = lv;
        clr_a[d] = clr;
        push(d, c, ov, un, st, name);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        @(negedge clk);
        for (int i = 0; i < NDut; i++) begin
            rst_a[i] = 1'b1;
            push(i, 8'd0, 1'b0, 1'b0, 1'b0, "reset");
        end

        // Free count up on the default configuration.
        for (int i = 1; i <= 10; i++) step(0, 0, 1, 1, 0, 0, 0, 8'(i), 0, 0, 0, "up_count");

        // Wrap at MAX_VAL=9.
        step(1, 0, 0, 0, 1, 8'd8, 0, 8'd8, 0, 0, 0, "load8");
        step(1, 0, 1, 1, 0, 0, 0, 8'd9, 0, 0, 0, "up_to_max");
        step(1, 0, 1, 1, 0, 0, 0, 8'd0, 1, 0, 1, "wrap_over");
        step(1, 0, 1, 1, 0, 0, 0, 8'd1, 0, 0, 1, "after_wrap");
        step(1, 0, 1, 0, 0, 0, 0, 8'd0, 0, 0, 1, "down_to_0");
        step(1, 0, 1, 0, 0, 0, 0, 8'd9, 0, 1, 1, "wrap_under");
        step(1, 0, 0, 0, 1, 8'd10, 0, 8'd9, 0, 0, 1, "load_clamp10");

        // Saturate at zero: back-to-back underflow pulses.
        step(2, 0, 1, 0, 0, 0, 0, 8'd0, 0, 1, 1, "sat_under1");
        step(2, 0, 1, 0, 0, 0, 0, 8'd0, 0, 1, 1, "sat_under2");
        step(2, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 1, "pulse_ends");
        step(2, 0, 0, 0, 0, 0, 1, 8'd0, 0, 0, 0, "clr_sticky");
        step(2, 0, 0, 0, 1, 8'd9, 0, 8'd9, 0, 0, 0, "load_max");
        step(2, 0, 1, 1, 0, 0, 0, 8'd9, 1, 0, 1, "sat_over");

        // Load beats enable, with clamp; then clear/set priority.
        step(3, 0, 1, 1, 1, 8'd200, 0, 8'd99, 0, 0, 0, "load_over_en");
        step(3, 0, 1, 1, 0, 0, 0, 8'd0, 1, 0, 1, "wrap99");
        step(3, 0, 0, 0, 1, 8'd99, 0, 8'd99, 0, 0, 1, "reload99");
        step(3, 0, 1, 1, 0, 0, 1, 8'd0, 1, 0, 1, "set_beats_clr");
        step(3, 0, 0, 0, 0, 0, 1, 8'd0, 0, 0, 0, "clr_alone");
        step(3, 0, 1, 0, 0, 0, 0, 8'd99, 0, 1, 1, "under99");

        // Reset mid-count with enable held.
        step(0, 0, 0, 0, 1, 8'd5, 0, 8'd5, 0, 0, 0, "load5");
        step(0, 1, 1, 1, 0, 0, 0, 8'd0, 0, 0, 0, "rst_mid");
        step(0, 0, 1, 1, 0, 0, 0, 8'd1, 0, 0, 0, "resume1");
        step(0, 0, 1, 1, 0, 0, 0, 8'd2, 0, 0, 0, "resume2");

        @(negedge clk);
        idle_all();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
